// File: rtl/r_clk_fwft_module_pkg.sv
// Shared constants for the dual-clock FIFO read side.
package r_clk_fwft_module_pkg;

  localparam int ADDRESS_SIZE_DEF = 2;
  localparam int DATA_SIZE_DEF    = 8;

  // One extra pointer bit separates full from empty after a wrap.
  function automatic int ptr_width(input int address_size);
    return address_size + 1;
  endfunction

endpackage

// File: rtl/r_clk_fwft_module_gray_to_binary.sv
// Combinational Gray-to-binary decode; bit i is the XOR of all Gray bits at or above i.
module gray_to_binary #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_gray,
  output logic [N-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < N; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/r_clk_fwft_module.sv
// FIFO read-domain control: pointer sync, registered empty, RAM fetch and a
// 2-entry first-word-fall-through output buffer.
module r_clk_fwft_module
  import r_clk_fwft_module_pkg::*;
#(
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int DATA_SIZE    = DATA_SIZE_DEF
) (
  input  logic                                r_clk,
  input  logic                                rrst,
  input  logic [ptr_width(ADDRESS_SIZE)-1:0]  w_ptr,
  output logic [ptr_width(ADDRESS_SIZE)-1:0]  r_ptr,
  output logic [ADDRESS_SIZE-1:0]             r_addr,
  output logic                                r_mem_en,
  input  logic [DATA_SIZE-1:0]                r_data_mem,
  output logic [DATA_SIZE-1:0]                r_data,
  output logic                                r_valid,
  input  logic                                r_ready,
  output logic                                r_empty,
  output logic [ptr_width(ADDRESS_SIZE)-1:0]  r_level
);

  localparam int PW = ptr_width(ADDRESS_SIZE);

  logic [PW-1:0]        r_bin;
  logic [PW-1:0]        r_rq1;
  logic [PW-1:0]        r_rq2;
  logic [1:0]           r_cnt;
  logic                 r_inflight;
  logic [DATA_SIZE-1:0] r_buf0;
  logic [DATA_SIZE-1:0] r_buf1;

  logic                 w_deq;
  logic                 w_fetch;
  logic [2:0]           w_occ;
  logic [PW-1:0]        w_bnext;
  logic [PW-1:0]        w_gnext;
  logic [PW-1:0]        w_wbin;

  gray_to_binary #(.N(PW)) u_g2b (
    .i_gray (r_rq2),
    .o_bin  (w_wbin)
  );

  assign r_valid = (r_cnt != 2'd0);
  assign r_data  = r_buf0;
  assign r_addr  = r_bin[ADDRESS_SIZE-1:0];
  assign w_deq   = r_valid & r_ready;

  // Words held or on their way, after this cycle's dequeue; never exceeds 2.
  assign w_occ    = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_fetch  = !r_empty && (w_occ < 3'd2);
  assign r_mem_en = w_fetch;
  assign w_bnext  = r_bin + {{(PW-1){1'b0}}, w_fetch};
  assign w_gnext  = w_bnext ^ (w_bnext >> 1);

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      r_rq1      <= '0;
      r_rq2      <= '0;
      r_bin      <= '0;
      r_ptr      <= '0;
      r_empty    <= 1'b1;
      r_level    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_rq1      <= w_ptr;
      r_rq2      <= r_rq1;
      r_bin      <= w_bnext;
      r_ptr      <= w_gnext;
      r_empty    <= (w_gnext == r_rq2);
      r_level    <= w_wbin - w_bnext;
      r_inflight <= w_fetch;
    end
  end

  // Head stays in r_buf0 so r_data never moves while the consumer stalls.
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      r_cnt  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({r_inflight, w_deq})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= r_data_mem;
          else               r_buf1 <= r_data_mem;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_buf0 <= r_data_mem;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= r_data_mem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r_clk_fwft_module.sv
// Bench for the FIFO read side: RAM and write-pointer model, scoreboard monitor.
module tb_r_clk_fwft_module;

  logic       r_clk = 1'b0;
  logic       rrst = 1'b1;
  logic [2:0] w_ptr = 3'd0;
  logic [2:0] r_ptr;
  logic [1:0] r_addr;
  logic       r_mem_en;
  logic [7:0] r_data_mem = 8'd0;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ready = 1'b0;
  logic       r_empty;
  logic [2:0] r_level;

  int checks = 0;
  int failures = 0;
  int npop = 0;

  logic [7:0] mem [4];
  logic [7:0] q [$];
  logic [2:0] wbin = 3'd0;

  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [2:0] prev_ptr = 3'd0;

  r_clk_fwft_module #(.ADDRESS_SIZE(2), .DATA_SIZE(8)) dut (
    .r_clk      (r_clk),
    .rrst       (rrst),
    .w_ptr      (w_ptr),
    .r_ptr      (r_ptr),
    .r_addr     (r_addr),
    .r_mem_en   (r_mem_en),
    .r_data_mem (r_data_mem),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_empty    (r_empty),
    .r_level    (r_level)
  );

  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) begin
    if (r_mem_en) r_data_mem <= mem[r_addr];
  end

  function automatic logic [2:0] b2g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge r_clk) begin
    if (!rrst) begin
      if (r_valid && r_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {24'd0, r_data}, 32'hFFFF_FFFF);
        end else begin
          chk("data_order", {24'd0, r_data}, {24'd0, q.pop_front()});
          npop++;
        end
      end
      if (prev_hold && r_valid) chk("data_stable", {24'd0, r_data}, {24'd0, prev_data});
      if (r_ptr != prev_ptr) chk("gray_step", {29'd0, r_ptr}, {29'd0, b2g(g2b(prev_ptr) + 3'd1)});
      if (r_mem_en) chk("read_not_empty", {31'd0, r_empty}, 32'd0);
    end
    prev_hold = r_valid && !r_ready && !rrst;
    prev_data = r_data;
    prev_ptr  = rrst ? 3'd0 : r_ptr;
  end

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    step();
    rrst = 1'b1;
    w_ptr = 3'd0;
    wbin = 3'd0;
    q.delete();
    repeat (n) step();
    rrst = 1'b0;
  endtask

  task automatic put_word(input logic [7:0] d);
    mem[wbin[1:0]] = d;
    q.push_back(d);
    wbin = wbin + 3'd1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    @(negedge r_clk);
    while (!r_valid && n < budget) begin
      @(negedge r_clk);
      n++;
    end
    if (!r_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int fetches;
    int seen;
    int start;
    logic [2:0] diff;
    logic [7:0] d;

    for (int i = 0; i < 4; i++) mem[i] = 8'd0;

    // Reset state
    repeat (2) step();
    @(negedge r_clk);
    chk("rst_empty", {31'd0, r_empty}, 32'd1);
    chk("rst_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_ptr", {29'd0, r_ptr}, 32'd0);
    chk("rst_level", {29'd0, r_level}, 32'd0);
    chk("rst_mem_en", {31'd0, r_mem_en}, 32'd0);
    rrst = 1'b0;
    r_ready = 1'b1;
    repeat (2) step();

    // Single word: latency from w_ptr change
    step();
    put_word(8'hA5);
    w_ptr = b2g(wbin);
    for (int c = 0; c < 7; c++) begin
      @(negedge r_clk);
      if (c == 2) chk("sw_empty_c2", {31'd0, r_empty}, 32'd1);
      if (c == 3) begin
        chk("sw_empty_c3", {31'd0, r_empty}, 32'd0);
        chk("sw_mem_en_c3", {31'd0, r_mem_en}, 32'd1);
        chk("sw_addr_c3", {30'd0, r_addr}, 32'd0);
      end
      if (c == 4) begin
        chk("sw_empty_c4", {31'd0, r_empty}, 32'd1);
        chk("sw_valid_c4", {31'd0, r_valid}, 32'd0);
      end
      if (c == 5) chk("sw_valid_c5", {31'd0, r_valid}, 32'd1);
      if (c == 6) chk("sw_valid_c6", {31'd0, r_valid}, 32'd0);
    end
    chk("sw_ptr", {29'd0, r_ptr}, 32'd1);
    chk("sw_popped", npop, 32'd1);

    // Streaming 4 words
    do_reset(2);
    r_ready = 1'b1;
    step();
    put_word(8'h11); put_word(8'h22); put_word(8'h33); put_word(8'h44);
    w_ptr = b2g(wbin);
    start = npop;
    wait_valid(20, "stream");
    seen = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge r_clk);
      if (r_valid) seen++;
    end
    chk("stream_consecutive", seen, 32'd4);
    repeat (4) step();
    chk("stream_popped", npop - start, 32'd4);
    chk("stream_ptr", {29'd0, r_ptr}, 32'd6);

    // Backpressure
    do_reset(2);
    r_ready = 1'b0;
    step();
    put_word(8'hC0); put_word(8'hC1); put_word(8'hC2); put_word(8'hC3);
    w_ptr = b2g(wbin);
    fetches = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge r_clk);
      if (r_mem_en) fetches++;
    end
    chk("bp_fetches", fetches, 32'd2);
    chk("bp_level", {29'd0, r_level}, 32'd2);
    chk("bp_valid", {31'd0, r_valid}, 32'd1);
    chk("bp_head", {24'd0, r_data}, 32'hC0);
    start = npop;
    step();
    r_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge r_clk);
      if (r_valid) seen++;
    end
    chk("bp_consecutive", seen, 32'd4);
    repeat (3) step();
    chk("bp_popped", npop - start, 32'd4);

    // Wrap: 10 words through depth 4 with random ready
    do_reset(2);
    start = npop;
    seen = 0;
    for (int c = 0; c < 400 && (npop - start) < 10; c++) begin
      step();
      r_ready = 1'($urandom_range(0, 1));
      diff = wbin - g2b(r_ptr);
      if (seen < 10 && diff < 3'd4) begin
        d = 8'h50 + 8'(seen);
        put_word(d);
        w_ptr = b2g(wbin);
        seen++;
      end
    end
    r_ready = 1'b1;
    repeat (3) step();
    chk("wrap_popped", npop - start, 32'd10);
    chk("wrap_ptr", {29'd0, r_ptr}, 32'd3);
    chk("wrap_empty", {31'd0, r_empty}, 32'd1);

    // Reset while a word is buffered and another in flight
    do_reset(2);
    r_ready = 1'b1;
    step();
    put_word(8'hE0); put_word(8'hE1); put_word(8'hE2); put_word(8'hE3);
    w_ptr = b2g(wbin);
    wait_valid(20, "mid");
    step();
    rrst = 1'b1;
    r_ready = 1'b0;
    w_ptr = 3'd0;
    wbin = 3'd0;
    q.delete();
    step();
    @(negedge r_clk);
    chk("mid_valid", {31'd0, r_valid}, 32'd0);
    chk("mid_ptr", {29'd0, r_ptr}, 32'd0);
    chk("mid_empty", {31'd0, r_empty}, 32'd1);
    step();
    rrst = 1'b0;
    r_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge r_clk);
      if (r_valid) seen++;
    end
    chk("mid_no_stale", seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
